// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
//   In-order DDR4 command scheduler. Requests (read / write / instruction
//   fetch) enter a QDEPTH-deep FIFO. The head entry is decoded into bank
//   group, bank, row and column. PRE/ACT/RD/WR are issued for it under an
//   open-page policy, one command per cycle, with per-bank timing tracking.
//   All timing values are in DRAM clocks and are scaled by CLK_RATIO.
// Ports
//   i_clk, i_rst        controller clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_op, i_req_addr   request handshake
//   o_cmd_valid, o_cmd_type, o_cmd_bg, o_cmd_bank, o_cmd_row, o_cmd_col
//                       registered command pulse (0 PRE, 1 ACT, 2 RD, 3 WR)
//   o_done_valid, o_done_op   head request completed and popped
//   o_q_count           queue occupancy

// Per-bank open-row state and saturating "cycles since" counters.
module dram_bank_state (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_act,
  input  logic        i_pre,
  input  logic        i_rd,
  input  logic        i_wr_end,
  input  logic [14:0] i_row,
  output logic        o_open,
  output logic [14:0] o_row,
  output logic [7:0]  o_since_act,
  output logic [7:0]  o_since_rd,
  output logic [7:0]  o_since_wr
);
  logic        r_open;
  logic [14:0] r_row;
  logic [7:0]  r_sa, r_sr, r_sw;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_open <= 1'b0;
      r_row  <= '0;
      r_sa   <= 8'hFF;
      r_sr   <= 8'hFF;
      r_sw   <= 8'hFF;
    end else begin
      if (i_sel && i_act) begin
        r_open <= 1'b1;
        r_row  <= i_row;
      end else if (i_sel && i_pre) begin
        r_open <= 1'b0;
      end
      r_sa <= (i_sel && i_act)    ? 8'd0 : sat_inc(r_sa);
      r_sr <= (i_sel && i_rd)     ? 8'd0 : sat_inc(r_sr);
      r_sw <= (i_sel && i_wr_end) ? 8'd0 : sat_inc(r_sw);
    end
  end

  assign o_open      = r_open;
  assign o_row       = r_row;
  assign o_since_act = r_sa;
  assign o_since_rd  = r_sr;
  assign o_since_wr  = r_sw;
endmodule

module dram_cmd_scheduler #(
  parameter int QDEPTH    = 16,
  parameter int NBG       = 4,
  parameter int NBANK     = 4,
  parameter int ADDR_W    = 33,
  parameter int CLK_RATIO = 2,
  parameter int T_RP      = 24,
  parameter int T_RCD     = 24,
  parameter int T_CAS     = 24,
  parameter int T_CWL     = 20,
  parameter int T_BURST   = 4,
  parameter int T_RAS     = 52,
  parameter int T_WR      = 20,
  parameter int T_RTP     = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [1:0]                    i_req_op,
  input  logic [ADDR_W-1:0]             i_req_addr,
  output logic                          o_cmd_valid,
  output logic [1:0]                    o_cmd_type,
  output logic [1:0]                    o_cmd_bg,
  output logic [1:0]                    o_cmd_bank,
  output logic [14:0]                   o_cmd_row,
  output logic [7:0]                    o_cmd_col,
  output logic                          o_done_valid,
  output logic [1:0]                    o_done_op,
  output logic [$clog2(QDEPTH+1)-1:0]   o_q_count
);
  localparam int NB = NBG * NBANK;
  localparam int BW = $clog2(NB);
  localparam int QW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int HW = ADDR_W - 6;   // stored address bits: row, col, bank, bg

  localparam logic [7:0] TRP_C  = 8'(T_RP * CLK_RATIO);
  localparam logic [7:0] TRD_C  = 8'((T_CAS + T_BURST) * CLK_RATIO);
  localparam logic [7:0] TWD_C  = 8'((T_CWL + T_BURST) * CLK_RATIO);
  localparam logic [8:0] TRCD_C = 9'(T_RCD * CLK_RATIO);
  localparam logic [8:0] TRAS_C = 9'(T_RAS * CLK_RATIO);
  localparam logic [8:0] TRTP_C = 9'(T_RTP * CLK_RATIO);
  localparam logic [8:0] TWR_C  = 9'(T_WR * CLK_RATIO);

  localparam logic [1:0] C_PRE = 2'd0, C_ACT = 2'd1, C_RD = 2'd2, C_WR = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_COL, S_DATA} state_t;

  // ---------------- request queue ----------------
  logic [1:0]    r_q_op   [QDEPTH];
  logic [HW-1:0] r_q_addr [QDEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [QW-1:0] r_count, w_cnt_nxt;
  logic          r_ready, r_fresh;
  logic          w_push, w_pop, w_head_vld;
  logic          w_unused;

  assign w_unused  = ^i_req_addr[5:0];
  assign w_push    = i_req_valid && r_ready && (i_req_op != 2'd3);
  assign w_cnt_nxt = r_count + QW'(w_push) - QW'(w_pop);
  // An entry written into the head slot on the last edge is not scheduled
  // until the following cycle, so a request is at the head one cycle after
  // it is accepted.
  assign w_head_vld = (r_count != '0) && !r_fresh;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_op[r_wr]   <= i_req_op;
      r_q_addr[r_wr] <= i_req_addr[ADDR_W-1:6];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(QDEPTH-1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PW'(QDEPTH-1)) ? '0 : r_rd + 1'b1;
      r_count <= w_cnt_nxt;
      // Registered from the next count, so a full queue stays not-ready
      // through the pop cycle and reopens one cycle later.
      r_ready <= (w_cnt_nxt < QW'(QDEPTH));
      r_fresh <= w_push && ((r_count == '0) || ((r_count == QW'(1)) && w_pop));
    end
  end

  // ---------------- head decode ----------------
  logic [1:0]    w_h_op, w_h_bg, w_h_bk;
  logic [HW-1:0] w_h_a;
  logic [7:0]    w_h_col;
  logic [14:0]   w_h_row;
  logic [BW-1:0] w_bidx;

  assign w_h_op  = r_q_op[r_rd];
  assign w_h_a   = r_q_addr[r_rd];
  assign w_h_bg  = w_h_a[1:0];
  assign w_h_bk  = w_h_a[3:2];
  assign w_h_col = w_h_a[11:4];
  assign w_h_row = w_h_a[HW-1:12];
  assign w_bidx  = BW'(int'(w_h_bg) * NBANK + int'(w_h_bk));

  // ---------------- per-bank state ----------------
  logic [NB-1:0]       w_open_v;
  logic [NB-1:0][14:0] w_row_v;
  logic [NB-1:0][7:0]  w_sa_v, w_sr_v, w_sw_v;
  logic                w_iss;
  logic [1:0]          w_typ;
  logic                w_wr_end;

  assign w_wr_end = w_pop && (w_h_op == 2'd1);

  for (genvar b = 0; b < NB; b++) begin : g_bank
    dram_bank_state u_bank (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_sel       (w_bidx == BW'(b)),
      .i_act       (w_iss && (w_typ == C_ACT)),
      .i_pre       (w_iss && (w_typ == C_PRE)),
      .i_rd        (w_iss && (w_typ == C_RD)),
      .i_wr_end    (w_wr_end),
      .i_row       (w_h_row),
      .o_open      (w_open_v[b]),
      .o_row       (w_row_v[b]),
      .o_since_act (w_sa_v[b]),
      .o_since_rd  (w_sr_v[b]),
      .o_since_wr  (w_sw_v[b])
    );
  end

  // Counter value seen on the issuing edge is one more than the current one.
  function automatic logic ge(input logic [7:0] cnt, input logic [8:0] thr);
    return ({1'b0, cnt} + 9'd1) >= thr;
  endfunction

  logic w_pre_ok, w_rcd_ok;
  assign w_pre_ok = ge(w_sa_v[w_bidx], TRAS_C) && ge(w_sr_v[w_bidx], TRTP_C) &&
                    ge(w_sw_v[w_bidx], TWR_C);
  assign w_rcd_ok = ge(w_sa_v[w_bidx], TRCD_C);

  // ---------------- FSM ----------------
  state_t     r_state, w_eff, w_nstate;
  logic [7:0] r_wait, w_wait_nxt;

  always_comb begin
    // IDLE classifies the head and acts as that state in the same cycle, so
    // a ready command leaves one cycle after the head becomes visible.
    w_eff = r_state;
    if (r_state == S_IDLE && w_head_vld) begin
      if (!w_open_v[w_bidx])                  w_eff = S_ACT;
      else if (w_row_v[w_bidx] == w_h_row)    w_eff = S_COL;
      else                                    w_eff = S_PRE;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_iss      = 1'b0;
    w_typ      = C_PRE;
    w_pop      = 1'b0;
    w_wait_nxt = (r_wait != 8'd0) ? r_wait - 8'd1 : 8'd0;
    case (w_eff)
      S_PRE: begin
        w_nstate = S_PRE;
        if (w_pre_ok) begin
          w_iss      = 1'b1;
          w_typ      = C_PRE;
          w_nstate   = S_ACT;
          w_wait_nxt = TRP_C;
        end
      end
      S_ACT: begin
        w_nstate = S_ACT;
        if (r_wait <= 8'd1) begin
          w_iss    = 1'b1;
          w_typ    = C_ACT;
          w_nstate = S_COL;
        end
      end
      S_COL: begin
        w_nstate = S_COL;
        if (w_rcd_ok) begin
          w_iss      = 1'b1;
          w_typ      = (w_h_op == 2'd1) ? C_WR : C_RD;
          w_nstate   = S_DATA;
          w_wait_nxt = (w_h_op == 2'd1) ? TWD_C : TRD_C;
        end
      end
      S_DATA: begin
        if (r_wait <= 8'd1) begin
          w_pop    = 1'b1;
          w_nstate = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_nstate;
      r_wait  <= w_wait_nxt;
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cmd_valid  <= 1'b0;
      o_cmd_type   <= 2'd0;
      o_cmd_bg     <= 2'd0;
      o_cmd_bank   <= 2'd0;
      o_cmd_row    <= '0;
      o_cmd_col    <= '0;
      o_done_valid <= 1'b0;
      o_done_op    <= 2'd0;
    end else begin
      o_cmd_valid  <= w_iss;
      o_cmd_type   <= w_iss ? w_typ : 2'd0;
      o_cmd_bg     <= w_iss ? w_h_bg : 2'd0;
      o_cmd_bank   <= w_iss ? w_h_bk : 2'd0;
      o_cmd_row    <= (w_iss && w_typ == C_ACT) ? w_h_row : '0;
      o_cmd_col    <= (w_iss && (w_typ == C_RD || w_typ == C_WR)) ? w_h_col : '0;
      o_done_valid <= w_pop;
      o_done_op    <= w_pop ? w_h_op : 2'd0;
    end
  end

  assign o_req_ready = r_ready;
  assign o_q_count   = r_count;
endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

Synthesizable DDR4 command scheduler that replaces the fixed PRE→ACT→RD sequencing of the behavioural controller model. It accepts processor requests (read, write, instruction fetch) into a parametrised in-order queue, decodes each address into bank group, bank, row and column, and tracks open-row state and timing counters per bank. It then issues PRE/ACT/RD/WR under an open-page policy, one command per cycle, and signals completion when each data burst ends. It sits between the trace-driven request source and the DRAM command logger/model.

## Interface
- QDEPTH, 16: request queue depth
- NBG, 4: bank groups (index = addr[7:6])
- NBANK, 4: banks per group (index = addr[9:8])
- ADDR_W, 33: address width; row = addr[32:18], col = addr[17:10]
- CLK_RATIO, 2: controller clocks per DRAM clock; every timing value below is multiplied by it
- T_RP 24, T_RCD 24, T_CAS 24, T_CWL 20, T_BURST 4, T_RAS 52, T_WR 20, T_RTP 12: DRAM-clock timings
- clk  in  1  controller clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  queue can accept (count < QDEPTH)
- req_op  in  2  0 read, 1 write, 2 instruction fetch (treated as read); 3 is illegal
- req_addr  in  ADDR_W  byte address
- cmd_valid  out  1  command issued this cycle
- cmd_type  out  2  0 PRE, 1 ACT, 2 RD, 3 WR
- cmd_bg, cmd_bank  out  2 each  target bank group and bank
- cmd_row  out  15  row (ACT only; 0 otherwise)
- cmd_col  out  8  column (RD/WR only; 0 otherwise)
- done_valid  out  1  head request completed and popped
- done_op  out  2  op of the completed request
- q_count  out  $clog2(QDEPTH+1)  current occupancy

## Operation
- Push on req_valid && req_ready. A req_op of 3 is dropped: it is not pushed, and the handshake still completes.
- Only the head entry is scheduled; there is no reordering.
- Per-bank state: open flag, open row, and saturating counters for cycles since last ACT, since last RD, and since the end of the last WR burst.
- FSM states: IDLE, PRE, ACT, COL, DATA.
  - IDLE → classify head: hit (bank open, row equal) → COL; empty (bank closed) → ACT; miss (bank open, row differs) → PRE.
  - PRE issues when since-ACT ≥ T_RAS·R, since-RD ≥ T_RTP·R, and since-WR-end ≥ T_WR·R. It closes the bank, then moves to ACT after T_RP·R cycles.
  - ACT issues immediately, opens the row, resets since-ACT, then moves to COL.
  - COL issues RD (op 0/2) or WR (op 1) once since-ACT ≥ T_RCD·R, then moves to DATA.
  - DATA waits (T_CAS+T_BURST)·R after RD or (T_CWL+T_BURST)·R after WR. On the final cycle it asserts done_valid, pops the head, records the WR-end time, and returns to IDLE.
- The bank stays open after access (open-page policy).
- Counters saturate at 255.
- Push and pop in the same cycle leave q_count unchanged. When the queue is full, req_ready is low, even in a pop cycle.

## Timing
- Definition: cycle n is the cycle following clock edge n; R = CLK_RATIO.
- All outputs are registered.
- Reset values: cmd_valid 0, cmd_type/bg/bank/row/col 0, done_valid 0, done_op 0, q_count 0, req_ready 0 during rst then 1. All banks are closed, all counters are 255, and the FSM is IDLE.
- A request accepted at edge 0 is at the head in cycle 1. The first command for it has cmd_valid high in cycle 2 if its constraints are met.
- cmd_valid is a single-cycle pulse, and at most one command is issued per cycle.
- done_valid is a single-cycle pulse coincident with the pop. The next head is classified in the following cycle.
- Reset asserted mid-operation aborts the current sequence with no further commands, flushes the queue, and closes all banks. Commands and requests resume in the cycle after rst deasserts.

## Test plan
- **Empty bank read, R=2, addr 0x0_0004_0540** (row 1, col 1, bank 1, bg 1), accepted at edge 0:
  - ACT(1,1,row 1) in cycle 2
  - RD col 1 in cycle 50
  - done_valid in cycle 106
- **Row hit read** (same row, col 2) queued behind the first request: RD issued 1 cycle after the first done (cycle 107); done at cycle 163.
- **Row miss** (row 2, same bank) immediately after an ACT: PRE is held until since-ACT ≥ 104; ACT follows 48 cycles after PRE.
- **Write then miss in same bank:** PRE is not issued until 40 cycles after the WR burst end. Check the WR is followed by done at +48 cycles.
- **Queue full:** push 17 requests back-to-back.
  - req_ready deasserts at q_count=16.
  - The 17th is accepted only in the cycle after a pop.
  - req_op=3 is never pushed.
- **Reset during ACT→COL wait:**
  - No RD is issued.
  - q_count is 0 and req_ready is 1 in the cycle after rst falls.
  - A fresh read to the same row issues ACT (bank closed), not RD.
